// File: rtl/me_block_scheduler_pkg.sv
// me_pkg: shared types and limits for the motion-estimation block scheduler.
//   me_seq_state_t : sequencer state encoding
//   ADDR_W, CNT_W  : search-memory row address width and row counter width
//   *_MIN / *_MAX  : legal ranges for SR_ROWS, BLK_ROWS and PIPE_LAT
package me_pkg;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned CNT_W  = 7;

  localparam int unsigned SR_ROWS_MIN  = 1;
  localparam int unsigned SR_ROWS_MAX  = 64;
  localparam int unsigned BLK_ROWS_MIN = 1;
  localparam int unsigned BLK_ROWS_MAX = 64;
  localparam int unsigned PIPE_LAT_MIN = 0;
  localparam int unsigned PIPE_LAT_MAX = 15;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_CUR,
    LOAD_SR,
    SWEEP,
    DRAIN,
    DONE
  } me_seq_state_t;

endpackage

// File: rtl/me_block_scheduler_if.sv
// me_block_scheduler_if: host/datapath-facing signals of the block scheduler.
//   start, done_ready          : host requests (driven by master)
//   busy, done_valid           : status / result handshake
//   cur_refresh, cur_broadcast : current-block buffer control
//   sr_mem_write/sr_addr_write : search-memory fill
//   sr_mem_read/sr_addr_read   : candidate read sweep
//   cmp_refresh, cmp_work      : compare-stage control
//   vec_capture                : result vector latch pulse
//   busy_cycles                : only when ME_SEQ_CYCLE_CNT_EN is defined
// slave modport is the scheduler side; master is the host side.
interface me_block_scheduler_if;
  import me_pkg::*;

  logic              start;
  logic              done_ready;
  logic              busy;
  logic              cur_refresh;
  logic              cur_broadcast;
  logic              sr_mem_write;
  logic [ADDR_W-1:0] sr_addr_write;
  logic              sr_mem_read;
  logic [ADDR_W-1:0] sr_addr_read;
  logic              cmp_refresh;
  logic              cmp_work;
  logic              vec_capture;
  logic              done_valid;
`ifdef ME_SEQ_CYCLE_CNT_EN
  logic [15:0]       busy_cycles;

  modport slave (
    input  start, done_ready,
    output busy, cur_refresh, cur_broadcast, sr_mem_write, sr_addr_write,
           sr_mem_read, sr_addr_read, cmp_refresh, cmp_work, vec_capture,
           done_valid, busy_cycles
  );

  modport master (
    output start, done_ready,
    input  busy, cur_refresh, cur_broadcast, sr_mem_write, sr_addr_write,
           sr_mem_read, sr_addr_read, cmp_refresh, cmp_work, vec_capture,
           done_valid, busy_cycles
  );
`else
  modport slave (
    input  start, done_ready,
    output busy, cur_refresh, cur_broadcast, sr_mem_write, sr_addr_write,
           sr_mem_read, sr_addr_read, cmp_refresh, cmp_work, vec_capture,
           done_valid
  );

  modport master (
    output start, done_ready,
    input  busy, cur_refresh, cur_broadcast, sr_mem_write, sr_addr_write,
           sr_mem_read, sr_addr_read, cmp_refresh, cmp_work, vec_capture,
           done_valid
  );
`endif

endinterface

// File: rtl/me_block_scheduler_pipe_delay.sv
// me_pipe_delay: 1-bit shift register of DEPTH stages with async reset.
//   clk  : clock      rst : async active-high reset
//   din  : input bit  dout: din delayed DEPTH cycles (DEPTH=0 is a wire)
module me_pipe_delay #(
  parameter int unsigned DEPTH = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  if (DEPTH == 0) begin : g_wire
    assign dout = din;
  end else if (DEPTH == 1) begin : g_one
    logic q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) q <= 1'b0;
      else     q <= din;
    end
    assign dout = q;
  end else begin : g_chain
    logic [DEPTH-1:0] sr;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) sr <= '0;
      else     sr <= {sr[DEPTH-2:0], din};
    end
    assign dout = sr[DEPTH-1];
  end

endmodule

// File: rtl/me_block_scheduler.sv
// me_block_scheduler: start/done sequencer for one motion-estimation search.
// Sequence: LOAD_CUR (BLK_ROWS) -> LOAD_SR (SR_ROWS) -> SWEEP (SR_ROWS)
//           -> DRAIN (PIPE_LAT) -> DONE (until done_ready).
// Ports:
//   CLK   : clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : me_block_scheduler_if.slave (host handshake + datapath enables)
// Optional feature macro ME_SEQ_CYCLE_CNT_EN adds bus.busy_cycles, a
// saturating count of busy cycles for the most recent search.
module me_block_scheduler
  import me_pkg::*;
#(
  parameter int unsigned SR_ROWS  = 48,
  parameter int unsigned BLK_ROWS = 16,
  parameter int unsigned PIPE_LAT = 3
) (
  input  logic                 CLK,
  input  logic                 reset,
  me_block_scheduler_if.slave  bus
);

  if (SR_ROWS < SR_ROWS_MIN || SR_ROWS > SR_ROWS_MAX) begin : g_bad_sr_rows
    $error("me_block_scheduler: SR_ROWS out of range");
  end
  if (BLK_ROWS < BLK_ROWS_MIN || BLK_ROWS > BLK_ROWS_MAX) begin : g_bad_blk_rows
    $error("me_block_scheduler: BLK_ROWS out of range");
  end
  if (PIPE_LAT > PIPE_LAT_MAX) begin : g_bad_pipe_lat
    $error("me_block_scheduler: PIPE_LAT out of range");
  end

  localparam logic [CNT_W-1:0] BLK_LAST  = CNT_W'(BLK_ROWS - 1);
  localparam logic [CNT_W-1:0] SR_LAST   = CNT_W'(SR_ROWS - 1);
  localparam logic [CNT_W-1:0] PIPE_LAST = (PIPE_LAT == 0) ? '0 : CNT_W'(PIPE_LAT - 1);

  me_seq_state_t     state;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_inc;

  logic              busy;
  logic              cur_refresh;
  logic              cur_broadcast;
  logic              sr_mem_write;
  logic [ADDR_W-1:0] sr_addr_write;
  logic              sr_mem_read;
  logic [ADDR_W-1:0] sr_addr_read;
  logic              cmp_refresh;
  logic              vec_capture;
  logic              done_valid;
  logic              cmp_work;

  assign cnt_inc = cnt + 1'b1;

  // Outputs are registered with the value they must show in the state being
  // entered (or held), so every output is a flop with no input-to-output path.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      busy          <= 1'b0;
      cur_refresh   <= 1'b0;
      cur_broadcast <= 1'b0;
      sr_mem_write  <= 1'b0;
      sr_addr_write <= '0;
      sr_mem_read   <= 1'b0;
      sr_addr_read  <= '0;
      cmp_refresh   <= 1'b0;
      vec_capture   <= 1'b0;
      done_valid    <= 1'b0;
    end else begin
      cnt           <= cnt_inc;
      busy          <= 1'b1;
      cur_refresh   <= 1'b0;
      cur_broadcast <= 1'b0;
      sr_mem_write  <= 1'b0;
      sr_addr_write <= '0;
      sr_mem_read   <= 1'b0;
      sr_addr_read  <= '0;
      cmp_refresh   <= 1'b0;
      vec_capture   <= 1'b0;
      done_valid    <= 1'b0;
      case (state)
        IDLE: begin
          cnt  <= '0;
          busy <= bus.start;
          if (bus.start) begin
            state         <= LOAD_CUR;
            cur_refresh   <= 1'b1;
            cmp_refresh   <= 1'b1;
            cur_broadcast <= 1'b1;
          end
        end
        LOAD_CUR: begin
          if (cnt == BLK_LAST) begin
            state        <= LOAD_SR;
            cnt          <= '0;
            sr_mem_write <= 1'b1;
          end else begin
            cur_broadcast <= 1'b1;
          end
        end
        LOAD_SR: begin
          if (cnt == SR_LAST) begin
            state       <= SWEEP;
            cnt         <= '0;
            sr_mem_read <= 1'b1;
          end else begin
            sr_mem_write  <= 1'b1;
            sr_addr_write <= cnt_inc[ADDR_W-1:0];
          end
        end
        SWEEP: begin
          if (cnt == SR_LAST) begin
            cnt <= '0;
            if (PIPE_LAT == 0) begin
              state       <= DONE;
              vec_capture <= 1'b1;
              done_valid  <= 1'b1;
            end else begin
              state <= DRAIN;
            end
          end else begin
            sr_mem_read  <= 1'b1;
            sr_addr_read <= cnt_inc[ADDR_W-1:0];
          end
        end
        DRAIN: begin
          if (cnt == PIPE_LAST) begin
            state       <= DONE;
            cnt         <= '0;
            vec_capture <= 1'b1;
            done_valid  <= 1'b1;
          end
        end
        DONE: begin
          cnt <= '0;
          if (bus.done_ready) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            done_valid <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  me_pipe_delay #(
    .DEPTH (PIPE_LAT)
  ) u_cmp_delay (
    .clk  (CLK),
    .rst  (reset),
    .din  (sr_mem_read),
    .dout (cmp_work)
  );

`ifdef ME_SEQ_CYCLE_CNT_EN
  logic [15:0] busy_cycles;

  // Counts edges spent outside IDLE, so it settles on the busy-cycle total.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      busy_cycles <= '0;
    end else if (state == IDLE) begin
      if (bus.start) busy_cycles <= '0;
    end else if (busy_cycles != '1) begin
      busy_cycles <= busy_cycles + 16'd1;
    end
  end

  assign bus.busy_cycles = busy_cycles;
`endif

  assign bus.busy          = busy;
  assign bus.cur_refresh   = cur_refresh;
  assign bus.cur_broadcast = cur_broadcast;
  assign bus.sr_mem_write  = sr_mem_write;
  assign bus.sr_addr_write = sr_addr_write;
  assign bus.sr_mem_read   = sr_mem_read;
  assign bus.sr_addr_read  = sr_addr_read;
  assign bus.cmp_refresh   = cmp_refresh;
  assign bus.cmp_work      = cmp_work;
  assign bus.vec_capture   = vec_capture;
  assign bus.done_valid    = done_valid;

endmodule
